// File: rtl/trace_pkg.sv
// Shared definitions for the commit trace path: the ebreak encoding and the
// layout of one trace entry {instr, pre_pc, pc} with pc in the LSBs.
package trace_pkg;

    localparam logic [31:0] EBREAK_INSTR = 32'h00100073;

    // pc always starts at bit 0 of an entry
    localparam int PC_LSB = 0;

    // Offsets depend on the instance's XLEN/ILEN, so they are derived here
    function automatic int prePcLsb(input int xlen);
        return xlen;
    endfunction

    function automatic int instrLsb(input int xlen);
        return 2 * xlen;
    endfunction

    function automatic int traceW(input int xlen, input int ilen);
        return 2 * xlen + ilen;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers. The head is read combinationally
// from storage and forced to zero while empty. A push while full is only
// taken when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             doPush;
    logic             doPop;

    assign count  = wrPtr - rdPtr;
    assign empty  = (wrPtr == rdPtr);
    assign full   = (count == (AW + 1)'(DEPTH));
    assign doPop  = pop & ~empty;
    assign doPush = push & (~full | doPop);
    assign rdata  = empty ? '0 : mem[rdPtr[AW-1:0]];

    // Pointer update; reset discards contents by collapsing both pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + (AW + 1)'(1);
            if (doPop)  rdPtr <= rdPtr + (AW + 1)'(1);
        end
    end

    // Storage write; contents need no reset since empty masks the head
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/commit_trace_buf.sv
// Retire-side trace unit: buffers every retired {instr, pre_pc, pc} for a
// downstream consumer and keeps cycle/instret/drop/flow-break counters, a
// no-commit watchdog and ebreak halt detection.
//
// Handshake: an entry transfers on any cycle where tr_valid && tr_ready are
// both high at the rising clk edge; tr_data is stable while tr_valid is high
// and tr_ready is low; tr_ready is ignored while tr_valid is low.
module commit_trace_buf
    import trace_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int ILEN        = 32,
    parameter int DEPTH       = 8,
    parameter int CNT_W       = 64,
    parameter int WDOG_CYCLES = 1024,
    parameter bit EBREAK_HALT = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       commit,
    input  logic [ILEN-1:0]            commit_instr,
    input  logic [XLEN-1:0]            commit_pc,
    input  logic [XLEN-1:0]            commit_pre_pc,
    input  logic                       clr,
    output logic                       tr_valid,
    input  logic                       tr_ready,
    output logic [2*XLEN+ILEN-1:0]     tr_data,
    output logic [$clog2(DEPTH):0]     tr_count,
    output logic                       tr_full,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic [CNT_W-1:0]           cycle_cnt,
    output logic [CNT_W-1:0]           instret_cnt,
    output logic [CNT_W-1:0]           flow_brk_cnt,
    output logic                       wdog_timeout,
    output logic                       halted
);

    localparam int TRACE_W   = traceW(XLEN, ILEN);
    localparam int PREPC_LSB = prePcLsb(XLEN);
    localparam int INSTR_LSB = instrLsb(XLEN);
    localparam int IDLE_W    = $clog2(WDOG_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(WDOG_CYCLES - 1);

    logic               pop;
    logic               push;
    logic               dropEvt;
    logic               flowBrk;
    logic               isEbreak;
    logic               fifoEmpty;
    logic [TRACE_W-1:0] entry;
    logic [XLEN-1:0]    lastPrePc;
    logic               lastValid;
    logic [IDLE_W-1:0]  idleCnt;

    assign tr_valid = ~fifoEmpty;
    assign pop      = tr_valid & tr_ready;
    assign push     = commit & (~tr_full | pop);
    assign dropEvt  = commit & tr_full & ~pop;
    assign flowBrk  = commit & lastValid & (commit_pc != lastPrePc);
    assign isEbreak = EBREAK_HALT & commit & (commit_instr == ILEN'(EBREAK_INSTR));

    // Pack the retiring instruction into one trace entry
    always_comb begin
        entry = '0;
        entry[PC_LSB    +: XLEN] = commit_pc;
        entry[PREPC_LSB +: XLEN] = commit_pre_pc;
        entry[INSTR_LSB +: ILEN] = commit_instr;
    end

    sync_fifo #(
        .WIDTH (TRACE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (push),
        .pop   (pop),
        .wdata (entry),
        .rdata (tr_data),
        .full  (tr_full),
        .empty (fifoEmpty),
        .count (tr_count)
    );

    // Event counters and the sticky overflow flag; clr wins over increments
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt    <= '0;
            instret_cnt  <= '0;
            drop_cnt     <= '0;
            flow_brk_cnt <= '0;
            overflow     <= 1'b0;
        end else if (clr) begin
            cycle_cnt    <= '0;
            instret_cnt  <= '0;
            drop_cnt     <= '0;
            flow_brk_cnt <= '0;
            overflow     <= 1'b0;
        end else begin
            if (!halted) cycle_cnt    <= cycle_cnt + CNT_ONE;
            if (commit)  instret_cnt  <= instret_cnt + CNT_ONE;
            if (dropEvt) drop_cnt     <= drop_cnt + CNT_ONE;
            if (flowBrk) flow_brk_cnt <= flow_brk_cnt + CNT_ONE;
            if (dropEvt) overflow     <= 1'b1;
        end
    end

    // Remember the previous commit's predicted next PC for flow-break detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lastPrePc <= '0;
            lastValid <= 1'b0;
        end else if (clr) begin
            lastValid <= 1'b0;
        end else if (commit) begin
            lastPrePc <= commit_pre_pc;
            lastValid <= 1'b1;
        end
    end

    // No-commit watchdog: idle counter saturates at WDOG_CYCLES-1 and one more
    // idle cycle raises the sticky timeout; everything freezes while halted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idleCnt      <= '0;
            wdog_timeout <= 1'b0;
        end else if (clr) begin
            idleCnt      <= '0;
            wdog_timeout <= 1'b0;
        end else if (!halted) begin
            if (commit) begin
                idleCnt <= '0;
            end else if (idleCnt == IDLE_LAST) begin
                wdog_timeout <= 1'b1;
            end else begin
                idleCnt <= idleCnt + IDLE_ONE;
            end
        end
    end

    // Sticky halt once an ebreak retires
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted <= 1'b0;
        end else if (clr) begin
            halted <= 1'b0;
        end else if (isEbreak) begin
            halted <= 1'b1;
        end
    end

endmodule
